// File: rtl/tl_model_if.sv
// Signal bundle between the traffic-light controller side (master) and the
// intersection model (slave): light codes and arrivals in, sensors and occupancy out.
interface tl_model_if #(
   parameter int QW = 4
);
   logic [1:0]    La;
   logic [1:0]    Lb;
   logic          arr_a;
   logic          arr_al;
   logic          arr_b;
   logic          arr_bl;
   logic          Ta;
   logic          Tal;
   logic          Tb;
   logic          Tbl;
   logic [QW-1:0] cnt_a;
   logic [QW-1:0] cnt_al;
   logic [QW-1:0] cnt_b;
   logic [QW-1:0] cnt_bl;
   logic          ovf;
   logic          conflict;

   modport master (
      output La, Lb, arr_a, arr_al, arr_b, arr_bl,
      input  Ta, Tal, Tb, Tbl, cnt_a, cnt_al, cnt_b, cnt_bl, ovf, conflict
   );

   modport slave (
      input  La, Lb, arr_a, arr_al, arr_b, arr_bl,
      output Ta, Tal, Tb, Tbl, cnt_a, cnt_al, cnt_b, cnt_bl, ovf, conflict
   );
endinterface

// File: rtl/tl_traffic_model.sv
// Closed-loop intersection model: four lane queues fed by arrivals, drained while lit.
// Optional unsafe-light detector enabled by macro TL_MODEL_CONFLICT_EN.
module tl_traffic_model #(
   parameter int QW      = 4,
   parameter int DEP_CYC = 2
) (
   input logic       clk,
   input logic       reset,
   tl_model_if.slave bus
);

   localparam logic [3:0]    DEP_TC  = 4'(DEP_CYC - 1);
   localparam logic [QW-1:0] CNT_MAX = '1;
   localparam logic [QW-1:0] CNT_ONE = QW'(1);

   localparam logic [1:0] L_GREEN  = 2'b00;
   localparam logic [1:0] L_RED    = 2'b10;
   localparam logic [1:0] L_ARROW  = 2'b11;

   // lane index: 0 A straight, 1 A left, 2 B straight, 3 B left
   logic [QW-1:0] r_cnt [4];
   logic [3:0]    r_tmr [4];
   logic          r_ovf;

   logic [3:0]    w_perm;
   logic [3:0]    w_arr;
   logic [3:0]    w_dep;
   logic [QW-1:0] w_cnt_nxt [4];
   logic [3:0]    w_tmr_nxt [4];
   logic          w_ovf_set;
   logic          w_conflict;

   always_comb begin
      w_perm    = {bus.Lb == L_ARROW, bus.Lb == L_GREEN, bus.La == L_ARROW, bus.La == L_GREEN};
      w_arr     = {bus.arr_bl, bus.arr_b, bus.arr_al, bus.arr_a};
      w_dep     = '0;
      w_ovf_set = 1'b0;
      w_cnt_nxt = r_cnt;
      w_tmr_nxt = '{default: '0};
      for (int i = 0; i < 4; i++) begin
         if (w_perm[i] && (r_cnt[i] != '0)) begin
            if (r_tmr[i] == DEP_TC) w_dep[i] = 1'b1;
            else                    w_tmr_nxt[i] = r_tmr[i] + 4'd1;
         end
         // simultaneous arrival and departure leaves the count alone
         case ({w_arr[i], w_dep[i]})
            2'b10: begin
               if (r_cnt[i] == CNT_MAX) w_ovf_set = 1'b1;
               else                     w_cnt_nxt[i] = r_cnt[i] + CNT_ONE;
            end
            2'b01:   w_cnt_nxt[i] = r_cnt[i] - CNT_ONE;
            default: w_cnt_nxt[i] = r_cnt[i];
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt <= '{default: '0};
         r_tmr <= '{default: '0};
         r_ovf <= 1'b0;
      end else begin
         r_cnt <= w_cnt_nxt;
         r_tmr <= w_tmr_nxt;
         if (w_ovf_set) r_ovf <= 1'b1;
      end
   end

`ifdef TL_MODEL_CONFLICT_EN
   logic [1:0] r_prev_a;
   logic [1:0] r_prev_b;
   logic       r_conflict;
   logic       w_conf_set;

   // both streets non-red, or a green that skipped yellow (to red or arrow)
   always_comb begin
      w_conf_set = ((bus.La != L_RED) && (bus.Lb != L_RED))
                || ((r_prev_a == L_GREEN) && bus.La[1])
                || ((r_prev_b == L_GREEN) && bus.Lb[1]);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_prev_a   <= L_RED;
         r_prev_b   <= L_RED;
         r_conflict <= 1'b0;
      end else begin
         r_prev_a <= bus.La;
         r_prev_b <= bus.Lb;
         if (w_conf_set) r_conflict <= 1'b1;
      end
   end

   assign w_conflict = r_conflict;
`else
   assign w_conflict = 1'b0;
`endif

   assign bus.cnt_a    = r_cnt[0];
   assign bus.cnt_al   = r_cnt[1];
   assign bus.cnt_b    = r_cnt[2];
   assign bus.cnt_bl   = r_cnt[3];
   assign bus.Ta       = |r_cnt[0];
   assign bus.Tal      = |r_cnt[1];
   assign bus.Tb       = |r_cnt[2];
   assign bus.Tbl      = |r_cnt[3];
   assign bus.ovf      = r_ovf;
   assign bus.conflict = w_conflict;

endmodule
